compl_mul_pipe: RTL and testbench



---
 rtl/compl_mul_pkg.sv | 21 ++
 rtl/compl_mul_pipe_if.sv | 35 +++
 rtl/compl_mul_pipe_round_sat.sv | 50 +++++
 rtl/compl_mul_pipe.sv | 132 +++++++++++++
 tb/tb_compl_mul_pipe.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/compl_mul_pkg.sv
// Shared constants and types for the pipelined complex multiplier.
package compl_mul_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int SHIFT_DEF  = 16;
  localparam int OUT_W_DEF  = 19;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    RND_FLOOR     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_AWAY = 2'd2,
    RND_CONV      = 2'd3
  } rnd_mode_e;

  // Width of a full-precision sum of two products without loss.
  function automatic int sum_width(input int data_w);
    return 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/compl_mul_pipe_if.sv
// Sample-in / result-out bundle of the complex multiplier.
interface compl_mul_pipe_if
  import compl_mul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
);
  logic [DATA_W-1:0] data_a_i_i;
  logic [DATA_W-1:0] data_a_q_i;
  logic [DATA_W-1:0] data_b_i_i;
  logic [DATA_W-1:0] data_b_q_i;
  logic              valid_i;
  logic              ready_o;
  logic              conj_i;
  logic [1:0]        round_mode_i;
  logic [OUT_W-1:0]  data_i_o;
  logic [OUT_W-1:0]  data_q_o;
  logic              valid_o;
  logic              ready_i;
  logic              ovf_o;
  logic [CNT_W-1:0]  sat_cnt_o;
  logic              clr_i;

  modport slave (
    input  data_a_i_i, data_a_q_i, data_b_i_i, data_b_q_i,
    input  valid_i, conj_i, round_mode_i, ready_i, clr_i,
    output ready_o, data_i_o, data_q_o, valid_o, ovf_o, sat_cnt_o
  );

  modport master (
    output data_a_i_i, data_a_q_i, data_b_i_i, data_b_q_i,
    output valid_i, conj_i, round_mode_i, ready_i, clr_i,
    input  ready_o, data_i_o, data_q_o, valid_o, ovf_o, sat_cnt_o
  );
endinterface

// File: rtl/compl_mul_pipe_round_sat.sv
// Drops SHIFT LSBs with the selected tie rule, then clamps to OUT_W signed.
module round_sat
  import compl_mul_pkg::*;
#(
  parameter int IN_W  = 37,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [IN_W-1:0]  din,
  input  rnd_mode_e               mode,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);
  localparam int RW = IN_W + 1 - SHIFT;
  localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] sum;
  logic        [IN_W:0] bias;
  logic signed [RW-1:0] q;

  // Ties are steered by biasing just below or at one half before flooring.
  always_comb begin
    ext  = {din[IN_W-1], din};
    bias = '0;
    case (mode)
      RND_FLOOR:     bias = '0;
      RND_HALF_UP:   bias = HALF;
      RND_HALF_AWAY: bias = din[IN_W-1] ? HALF - (IN_W+1)'(1) : HALF;
      RND_CONV:      bias = HALF - (IN_W+1)'(1) + (IN_W+1)'(din[SHIFT]);
      default:       bias = '0;
    endcase
    sum = ext + $signed(bias);
    q   = sum[IN_W:SHIFT];
  end

  always_comb begin
    ovf  = 1'b0;
    dout = q[OUT_W-1:0];
    if (q > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      ovf  = 1'b1;
    end else if (q < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      ovf  = 1'b1;
    end
  end
endmodule

// File: rtl/compl_mul_pipe.sv
// Three-stage complex multiplier (capture, products, add/round/saturate)
// with a single global stall and a saturating overflow counter.
module compl_mul_pipe
  import compl_mul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic             clk_i,
  input  logic             srst_i,
  compl_mul_pipe_if.slave  bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = sum_width(DATA_W);

  logic ce;

  logic                     v1, conj1;
  rnd_mode_e                mode1;
  logic signed [DATA_W-1:0] a_i, a_q, b_i, b_q;

  logic                     v2, conj2;
  rnd_mode_e                mode2;
  logic signed [PROD_W-1:0] p_ii, p_qq, p_iq, p_qi;

  logic signed [SUM_W-1:0]  sum_i, sum_q;
  logic signed [OUT_W-1:0]  r_i, r_q;
  logic                     ovf_i, ovf_q;

  logic                     v3, ovf3;
  logic [OUT_W-1:0]         d_i3, d_q3;
  logic [CNT_W-1:0]         sat_cnt;

  assign ce = !v3 || bus.ready_i;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      v1    <= 1'b0;
      conj1 <= 1'b0;
      mode1 <= RND_FLOOR;
      a_i   <= '0;
      a_q   <= '0;
      b_i   <= '0;
      b_q   <= '0;
    end else if (ce) begin
      v1    <= bus.valid_i;
      conj1 <= bus.conj_i;
      mode1 <= rnd_mode_e'(bus.round_mode_i);
      a_i   <= bus.data_a_i_i;
      a_q   <= bus.data_a_q_i;
      b_i   <= bus.data_b_i_i;
      b_q   <= bus.data_b_q_i;
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      v2    <= 1'b0;
      conj2 <= 1'b0;
      mode2 <= RND_FLOOR;
      p_ii  <= '0;
      p_qq  <= '0;
      p_iq  <= '0;
      p_qi  <= '0;
    end else if (ce) begin
      v2    <= v1;
      conj2 <= conj1;
      mode2 <= mode1;
      p_ii  <= a_i * b_i;
      p_qq  <= a_q * b_q;
      p_iq  <= a_i * b_q;
      p_qi  <= a_q * b_i;
    end
  end

  // Conjugating B flips the sign of every b_q product.
  always_comb begin
    if (conj2) begin
      sum_i = SUM_W'(p_ii) + SUM_W'(p_qq);
      sum_q = SUM_W'(p_qi) - SUM_W'(p_iq);
    end else begin
      sum_i = SUM_W'(p_ii) - SUM_W'(p_qq);
      sum_q = SUM_W'(p_iq) + SUM_W'(p_qi);
    end
  end

  round_sat #(.IN_W(SUM_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_i (
    .din  (sum_i),
    .mode (mode2),
    .dout (r_i),
    .ovf  (ovf_i)
  );

  round_sat #(.IN_W(SUM_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_q (
    .din  (sum_q),
    .mode (mode2),
    .dout (r_q),
    .ovf  (ovf_q)
  );

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      v3   <= 1'b0;
      ovf3 <= 1'b0;
      d_i3 <= '0;
      d_q3 <= '0;
    end else if (ce) begin
      v3   <= v2;
      ovf3 <= v2 && (ovf_i || ovf_q);
      d_i3 <= r_i;
      d_q3 <= r_q;
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      sat_cnt <= '0;
    end else if (bus.clr_i) begin
      sat_cnt <= '0;
    end else if (v3 && bus.ready_i && ovf3 && (sat_cnt != {CNT_W{1'b1}})) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

  assign bus.ready_o   = ce;
  assign bus.valid_o   = v3;
  assign bus.ovf_o     = ovf3;
  assign bus.data_i_o  = d_i3;
  assign bus.data_q_o  = d_q3;
  assign bus.sat_cnt_o = sat_cnt;
endmodule

// File: tb/tb_compl_mul_pipe.sv
// Directed bench for compl_mul_pipe: arithmetic model with a per-cycle compare.
module tb_compl_mul_pipe;
  localparam int DW = 18;
  localparam int SH = 16;
  localparam int OW = 19;

  typedef struct {
    longint i;
    longint q;
    bit     ov;
  } exp_t;

  logic clk = 1'b0;
  logic srst = 1'b1;

  compl_mul_pipe_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

  compl_mul_pipe #(.DATA_W(DW), .SHIFT(SH), .OUT_W(OW)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   cnt_m = 0;
  int   n_out = 0;
  bit   hold_v = 0;
  bit   saw_ready_low = 0;
  logic [OW-1:0] h_i, h_q;
  logic h_ov;

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic longint rnd(input longint x, input int mode);
    longint d, q, r, half;
    bit up;
    d = longint'(1) << SH;
    half = d / 2;
    q = x / d;
    r = x - q * d;
    if (r < 0) begin
      q = q - 1;
      r = r + d;
    end
    if (r > half) up = (mode != 0);
    else if (r == half)
      up = (mode == 1) || (mode == 2 && q >= 0) || (mode == 3 && (q & 1) != 0);
    else up = 0;
    return up ? q + 1 : q;
  endfunction

  function automatic longint sat(input longint x, inout bit ov);
    longint mx, mn;
    mx = (longint'(1) << (OW - 1)) - 1;
    mn = -(longint'(1) << (OW - 1));
    if (x > mx) begin ov = 1; return mx; end
    if (x < mn) begin ov = 1; return mn; end
    return x;
  endfunction

  function automatic exp_t model(input longint ai, aq, bi, bq, input bit cj, input int md);
    exp_t e;
    longint fi, fq;
    bit ov;
    if (cj) begin
      fi = ai * bi + aq * bq;
      fq = aq * bi - ai * bq;
    end else begin
      fi = ai * bi - aq * bq;
      fq = ai * bq + aq * bi;
    end
    ov = 0;
    e.i = sat(rnd(fi, md), ov);
    e.q = sat(rnd(fq, md), ov);
    e.ov = ov;
    return e;
  endfunction

  task automatic pin(input string name, input longint ai, aq, bi, bq, input bit cj,
                     input int md, input longint ei, eq, input bit eov);
    exp_t e;
    e = model(ai, aq, bi, bq, cj, md);
    chk({name, "_i"}, e.i, ei);
    chk({name, "_q"}, e.q, eq);
    chk({name, "_ov"}, longint'(e.ov), longint'(eov));
  endtask

  // Per-cycle compare against the model queue and the counter model.
  always @(negedge clk) begin
    exp_t e;
    if (srst) begin
      exp_q.delete();
      cnt_m = 0;
      hold_v = 0;
    end else begin
      chk("ready_rule", longint'(bus.ready_o), longint'(!bus.valid_o || bus.ready_i));
      if (!bus.ready_o) saw_ready_low = 1;
      if (hold_v) begin
        chk("hold_valid", longint'(bus.valid_o), 1);
        chk("hold_i", longint'(bus.data_i_o), longint'(h_i));
        chk("hold_q", longint'(bus.data_q_o), longint'(h_q));
        chk("hold_ovf", longint'(bus.ovf_o), longint'(h_ov));
      end
      chk("sat_cnt", longint'(bus.sat_cnt_o), longint'(cnt_m));
      e.ov = 0;
      if (bus.valid_o && bus.ready_i) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_i", longint'($signed(bus.data_i_o)), e.i);
          chk("out_q", longint'($signed(bus.data_q_o)), e.q);
          chk("out_ovf", longint'(bus.ovf_o), longint'(e.ov));
        end
      end
      if (bus.clr_i) cnt_m = 0;
      else if (bus.valid_o && bus.ready_i && e.ov && cnt_m < 65535) cnt_m++;
      hold_v = bus.valid_o && !bus.ready_i;
      h_i = bus.data_i_o;
      h_q = bus.data_q_o;
      h_ov = bus.ovf_o;
      if (bus.valid_i && bus.ready_o)
        exp_q.push_back(model($signed(bus.data_a_i_i), $signed(bus.data_a_q_i),
                              $signed(bus.data_b_i_i), $signed(bus.data_b_q_i),
                              bus.conj_i, int'(bus.round_mode_i)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ai, aq, bi, bq, input bit cj, input int md);
    int n;
    bit acc;
    bus.data_a_i_i = DW'(ai);
    bus.data_a_q_i = DW'(aq);
    bus.data_b_i_i = DW'(bi);
    bus.data_b_q_i = DW'(bq);
    bus.conj_i = cj;
    bus.round_mode_i = 2'(md);
    bus.valid_i = 1'b1;
    n = 0;
    acc = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.ready_o;
      step();
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    bus.valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.valid_o) && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", longint'(n < 200), 1);
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.valid_o && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, base;
    bus.data_a_i_i = '0;
    bus.data_a_q_i = '0;
    bus.data_b_i_i = '0;
    bus.data_b_q_i = '0;
    bus.valid_i = 1'b0;
    bus.conj_i = 1'b0;
    bus.round_mode_i = 2'd0;
    bus.ready_i = 1'b1;
    bus.clr_i = 1'b0;

    // Model pins against hand-computed literals.
    pin("pin_unit", 65536, 0, 3, 0, 0, 0, 3, 0, 0);
    pin("pin_h0", 1, 0, 32768, 0, 0, 0, 0, 0, 0);
    pin("pin_h1", 1, 0, 32768, 0, 0, 1, 1, 0, 0);
    pin("pin_h2", 1, 0, 32768, 0, 0, 2, 1, 0, 0);
    pin("pin_h3", 1, 0, 32768, 0, 0, 3, 0, 0, 0);
    pin("pin_t0", 3, 0, 32768, 0, 0, 0, 1, 0, 0);
    pin("pin_t3", 3, 0, 32768, 0, 0, 3, 2, 0, 0);
    pin("pin_n0", -1, 0, 32768, 0, 0, 0, -1, 0, 0);
    pin("pin_n1", -1, 0, 32768, 0, 0, 1, 0, 0, 0);
    pin("pin_n2", -1, 0, 32768, 0, 0, 2, -1, 0, 0);
    pin("pin_n3", -1, 0, 32768, 0, 0, 3, 0, 0, 0);
    pin("pin_sat", -131072, -131072, -131072, 131072, 0, 0, 262143, 0, 1);
    pin("pin_cj0", 65536, 65536, 0, 65536, 0, 0, -65536, 65536, 0);
    pin("pin_cj1", 65536, 65536, 0, 65536, 1, 0, 65536, -65536, 0);

    #2;
    chk("rst_valid", longint'(bus.valid_o), 0);
    chk("rst_i", longint'(bus.data_i_o), 0);
    chk("rst_q", longint'(bus.data_q_o), 0);
    chk("rst_ovf", longint'(bus.ovf_o), 0);
    chk("rst_cnt", longint'(bus.sat_cnt_o), 0);
    repeat (2) @(posedge clk);
    #3 srst = 1'b0;
    step();
    chk("rst_ready", longint'(bus.ready_o), 1);

    // Latency and literal result of a lone sample.
    send(65536, 0, 3, 0, 0, 0);
    wait_valid(n);
    chk("latency", n, 3);
    chk("lit_i", longint'($signed(bus.data_i_o)), 3);
    chk("lit_ovf", longint'(bus.ovf_o), 0);
    drain();

    // Rounding ties over all modes, streamed back to back.
    for (int m = 0; m < 4; m++) send(1, 0, 32768, 0, 0, m);
    for (int m = 0; m < 4; m++) send(3, 0, 32768, 0, 0, m);
    for (int m = 0; m < 4; m++) send(-1, 0, 32768, 0, 0, m);
    send(65536, 65536, 0, 65536, 0, 0);
    send(65536, 65536, 0, 65536, 1, 0);
    drain();

    // Saturation, counter increment, then clear winning over increment.
    send(-131072, -131072, -131072, 131072, 0, 0);
    drain();
    chk("cnt_after_sat", longint'(bus.sat_cnt_o), 1);
    send(-131072, -131072, -131072, 131072, 0, 0);
    wait_valid(n);
    chk("sat_wait", longint'(bus.valid_o), 1);
    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
    chk("cnt_after_clr", longint'(bus.sat_cnt_o), 0);
    drain();

    // Eight-sample stream with a five-cycle downstream stall.
    base = n_out;
    saw_ready_low = 0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 bus.ready_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.ready_i = 1'b1;
      end
    join_none
    send(1000, -2000, 3000, 4000, 0, 1);
    send(-131072, -131072, -131072, 131072, 0, 0);
    send(65536, 65536, 0, 65536, 1, 2);
    send(12345, -54321, -777, 8888, 1, 3);
    send(-100000, 50000, 70000, -30000, 0, 2);
    send(131071, 131071, 131071, 131071, 1, 1);
    send(-5, 7, 32768, -32768, 0, 3);
    send(98304, -98304, 2, 3, 0, 1);
    drain();
    chk("stall_ready_low", longint'(saw_ready_low), 1);
    chk("stream_count", n_out - base, 8);

    // Reset with two samples in flight.
    send(65536, 0, 5, 0, 0, 0);
    send(65536, 0, 7, 0, 0, 0);
    step();
    chk("pre_rst_valid", longint'(bus.valid_o), 1);
    #2 srst = 1'b1;
    #1;
    chk("mid_rst_valid", longint'(bus.valid_o), 0);
    chk("mid_rst_i", longint'(bus.data_i_o), 0);
    chk("mid_rst_cnt", longint'(bus.sat_cnt_o), 0);
    @(negedge clk);
    @(posedge clk);
    #3 srst = 1'b0;
    #1;
    chk("post_rst_ready", longint'(bus.ready_o), 1);
    base = n_out;
    send(65536, 0, 9, 0, 0, 0);
    wait_valid(n);
    chk("post_rst_latency", n, 3);
    chk("post_rst_i", longint'($signed(bus.data_i_o)), 9);
    drain();
    chk("post_rst_count", n_out - base, 1);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
